align_shifter: RTL and testbench

ALIGN_SHIFTER -- requirements
Module: align_shifter

---
 rtl/align_shifter.sv | 87 ++++++++
 tb/tb_align_shifter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/align_shifter.sv
// Iterative right-shift aligner for the smaller floating-point mantissa, producing guard/round/sticky.
// Define ALIGN_SHIFT4_EN to add a 4-bit-per-cycle shift step; results are identical in both builds.
module align_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  exp_diff,
    input  logic [23:0] mant_in,
    output logic        busy,
    output logic        done,
    output logic [23:0] mant_out,
    output logic [2:0]  grs
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bit 0 of shreg is sticky: every shift ORs the bits falling off the bottom into it.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (exp_diff < 8'd27) begin
                        shreg_d = {mant_in, 3'b000};
                        cnt_d   = exp_diff[4:0];
                    end else begin
                        shreg_d = {26'b0, |mant_in};
                        cnt_d   = 5'd0;
                    end
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == 5'd0) begin
                    state_d = DONE;
                end else begin
`ifdef ALIGN_SHIFT4_EN
                    if (cnt_q >= 5'd4) begin
                        shreg_d = {4'b0000, shreg_q[26:5], |shreg_q[4:0]};
                        cnt_d   = cnt_q - 5'd4;
                    end else begin
                        shreg_d = {1'b0, shreg_q[26:2], shreg_q[1] | shreg_q[0]};
                        cnt_d   = cnt_q - 5'd1;
                    end
`else
                    shreg_d = {1'b0, shreg_q[26:2], shreg_q[1] | shreg_q[0]};
                    cnt_d   = cnt_q - 5'd1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign mant_out = shreg_q[26:3];
    assign grs      = shreg_q[2:0];

endmodule

// File: tb/tb_align_shifter.sv
// Directed self-checking bench for align_shifter: alignment results, latency, saturation,
// busy-start rejection and reset abort.
module tb_align_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  exp_diff;
    logic [23:0] mant_in;
    logic        busy;
    logic        done;
    logic [23:0] mant_out;
    logic [2:0]  grs;

    int vectors;
    int miscompares;

    align_shifter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .exp_diff (exp_diff),
        .mant_in  (mant_in),
        .busy     (busy),
        .done     (done),
        .mant_out (mant_out),
        .grs      (grs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges from the start-sampling edge to the one after which done is visible.
    function automatic int exp_cycles(input int d);
        if (d >= 27) return 1;
`ifdef ALIGN_SHIFT4_EN
        return d / 4 + d % 4 + 1;
`else
        return d + 1;
`endif
    endfunction

    // Issues one start and counts edges until done; 200 means done never appeared.
    task automatic run_op(input logic [23:0] m, input logic [7:0] d, output int cycles);
        @(negedge clk);
        start    = 1'b1;
        mant_in  = m;
        exp_diff = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        mant_in  = 24'h5A5A5A;
        exp_diff = 8'hA5;
        cycles   = 0;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        mant_in  = 24'hFFFFFF;
        exp_diff = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, mant_out, grs} !== 29'd0) begin
            $display("[TB] FAIL reset_state: busy=%b done=%b mant_out=%h grs=%b, required all zero",
                     busy, done, mant_out, grs);
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_align(input logic [23:0] m, input logic [7:0] d,
                              input logic [23:0] exp_m, input logic [2:0] exp_g);
        int cycles;
        run_op(m, d, cycles);
        vectors++;
        if (cycles !== exp_cycles(int'(d))) begin
            $display("[TB] FAIL latency m=%h d=%0d: got %0d edges, required %0d",
                     m, d, cycles, exp_cycles(int'(d)));
            miscompares++;
        end
        vectors++;
        if (mant_out !== exp_m || grs !== exp_g) begin
            $display("[TB] FAIL result m=%h d=%0d: got mant_out=%h grs=%b, required %h %b",
                     m, d, mant_out, grs, exp_m, exp_g);
            miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL done_pulse m=%h d=%0d: got done=%b busy=%b after DONE, required 0 0",
                     m, d, done, busy);
            miscompares++;
        end
    endtask

    task automatic test_hold();
        int cycles;
        run_op(24'h123456, 8'd4, cycles);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (mant_out !== 24'h012345 || grs !== 3'b011) begin
            $display("[TB] FAIL hold: got mant_out=%h grs=%b, required 012345 011", mant_out, grs);
            miscompares++;
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        pulses = 0;
        @(negedge clk);
        start    = 1'b1;
        mant_in  = 24'h800000;
        exp_diff = 8'd8;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            $display("[TB] FAIL busy_after_start: got %b, required 1", busy);
            miscompares++;
        end
        start    = 1'b1;
        mant_in  = 24'hFFFFFF;
        exp_diff = 8'd1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (pulses !== 1) begin
            $display("[TB] FAIL ignore_start_pulses: got %0d done pulses, required 1", pulses);
            miscompares++;
        end
        vectors++;
        if (mant_out !== 24'h008000 || grs !== 3'b000) begin
            $display("[TB] FAIL ignore_start_result: got mant_out=%h grs=%b, required 008000 000",
                     mant_out, grs);
            miscompares++;
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int cycles;
        pulses = 0;
        @(negedge clk);
        start    = 1'b1;
        mant_in  = 24'hABCDEF;
        exp_diff = 8'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, mant_out, grs} !== 29'd0) begin
            $display("[TB] FAIL reset_abort_outputs: busy=%b done=%b mant_out=%h grs=%b, required all zero",
                     busy, done, mant_out, grs);
            miscompares++;
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            $display("[TB] FAIL reset_abort_no_done: got %0d done pulses, required 0", pulses);
            miscompares++;
        end
        run_op(24'hC00001, 8'd3, cycles);
        vectors++;
        if (cycles !== 4 || mant_out !== 24'h180000 || grs !== 3'b001) begin
            $display("[TB] FAIL post_reset_op: got edges=%0d mant_out=%h grs=%b, required 4 180000 001",
                     cycles, mant_out, grs);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        mant_in     = 24'h0;
        exp_diff    = 8'h0;

        test_reset();
        test_align(24'h800000, 8'd0,  24'h800000, 3'b000);
        test_align(24'hC00001, 8'd3,  24'h180000, 3'b001);
        test_align(24'h123456, 8'd4,  24'h012345, 3'b011);
        test_align(24'hFFFFFF, 8'd9,  24'h007FFF, 3'b111);
        test_align(24'h800000, 8'd24, 24'h000000, 3'b100);
        test_align(24'h800000, 8'd25, 24'h000000, 3'b010);
        test_align(24'h800000, 8'd26, 24'h000000, 3'b001);
        test_align(24'h800000, 8'd27, 24'h000000, 3'b001);
        test_align(24'h800000, 8'd40, 24'h000000, 3'b001);
        test_align(24'h000000, 8'd40, 24'h000000, 3'b000);
        test_hold();
        test_ignore_start();
        test_reset_abort();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
